// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, the master FSM state
// enum (reused by other bus masters) and a response-error helper.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        MST_IDLE,
        MST_RD,
        MST_WR,
        MST_WR_B,
        MST_RESP
    } axi_mst_state_e;

    // EXOKAY counts as success; only SLVERR/DECERR are errors.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with initiator (master) and target (slave) views.
interface axi4_lite_interface #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi4_lite_watchdog.sv
// Cycle watchdog for a bus transaction: clear restarts it, enable counts,
// expired flags the last allowed cycle (LIMIT-1).
module axi4_lite_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(LIMIT) + 1;

    logic [CW-1:0] count;

    assign expired = (count == CW'(LIMIT - 1));

    // Count cycles spent waiting on the slave; saturate once expired.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/axi4_lite_lsu_master.sv
// AXI4-Lite initiator for the LSU: one transaction at a time, read via
// AR/R and write via AW/W/B, single-cycle response pulse back to the core.
// Optional watchdog enabled by defining AXI_TIMEOUT_EN.
module axi4_lite_lsu_master
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    axi4_lite_interface.master  m_axi
);
    axi_mst_state_e state_q, state_d;

    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic                timeout_hit;

`ifdef AXI_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;

    assign wd_clear  = (state_q == MST_IDLE) && req_valid;
    assign wd_enable = (state_q == MST_RD) || (state_q == MST_WR) || (state_q == MST_WR_B);

    axi4_lite_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (timeout_hit)
    );
`else
    // Without the watchdog the limit has no meaning; the master waits forever.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    assign req_ready     = (state_q == MST_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;

    // Next-state and next-value logic for every registered bus/response output.
    always_comb begin
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            MST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (req_wen) begin
                        state_d   = MST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = MST_RD;
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                    end
                end
            end
            MST_RD: begin
                if (arvalid_q && m_axi.arready) begin
                    arvalid_d = 1'b0;
                end
                if (m_axi.rvalid && rready_q) begin
                    arvalid_d    = 1'b0;
                    rready_d     = 1'b0;
                    resp_rdata_d = m_axi.rdata;
                    resp_err_d   = resp_is_err(m_axi.rresp);
                    resp_valid_d = 1'b1;
                    state_d      = MST_RESP;
                end
            end
            MST_WR: begin
                if (awvalid_q && m_axi.awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m_axi.wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = MST_WR_B;
                end
            end
            MST_WR_B: begin
                if (m_axi.bvalid && bready_q) begin
                    bready_d     = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = resp_is_err(m_axi.bresp);
                    resp_valid_d = 1'b1;
                    state_d      = MST_RESP;
                end
            end
            MST_RESP: begin
                state_d = MST_IDLE;
            end
            default: begin
                state_d = MST_IDLE;
            end
        endcase

        // A stalled slave is abandoned: release the bus and report an error.
        if (timeout_hit &&
            ((state_q == MST_RD) || (state_q == MST_WR) || (state_q == MST_WR_B))) begin
            arvalid_d    = 1'b0;
            rready_d     = 1'b0;
            awvalid_d    = 1'b0;
            wvalid_d     = 1'b0;
            bready_d     = 1'b0;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = MST_RESP;
        end
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MST_IDLE;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end
endmodule

// File: tb/tb_axi4_lite_lsu_master.sv
// Bench for axi4_lite_lsu_master: a configurable-latency AXI4-Lite slave
// with a small memory, directed scenarios and a randomized run checked
// against a word-level memory/latency model. Honours AXI_TIMEOUT_EN.
module tb_axi4_lite_lsu_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad = 0;

    axi4_lite_interface #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi4_lite_lsu_master #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .m_axi      (bus)
    );

    always #5 clk = ~clk;

    // Slave configuration, set by the stimulus task before each request.
    int         ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [1:0] cur_resp = 2'b00;

    // Slave state.
    logic [31:0] smem [16];
    int          ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    logic        r_pend, aw_got, w_got, b_pend;
    logic [31:0] r_addr, w_addr, w_data;
    logic [3:0]  w_strb;
    logic [7:0]  uart_last;
    logic        ar_fire, aw_fire, w_fire;

    function automatic logic [31:0] initWord(input int i);
        return 32'h5a5a_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Combinational slave responses driven from the delay counters.
    assign bus.arready = bus.arvalid && (ar_cnt >= ar_delay);
    assign ar_fire     = bus.arvalid && bus.arready;
    assign bus.rvalid  = (ar_fire && (r_delay == 0)) || (r_pend && (r_cnt >= r_delay));
    assign bus.rdata   = r_pend ? smem[r_addr[5:2]] : smem[bus.araddr[5:2]];
    assign bus.rresp   = cur_resp;
    assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
    assign aw_fire     = bus.awvalid && bus.awready;
    assign bus.wready  = bus.wvalid && (w_cnt >= w_delay);
    assign w_fire      = bus.wvalid && bus.wready;
    assign bus.bvalid  = b_pend && (b_cnt >= b_delay);
    assign bus.bresp   = cur_resp;

    // Slave sequential behaviour: wait counters, pending R/B, memory writes.
    always @(posedge clk) begin
        if (rst) begin
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
            r_addr <= '0; w_addr <= '0; w_data <= '0; w_strb <= '0;
            uart_last <= '0;
            for (int i = 0; i < 16; i++) smem[i] <= initWord(i);
        end else begin
            ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
            if (ar_fire && !(bus.rvalid && bus.rready)) begin
                r_pend <= 1'b1;
                r_cnt  <= 1;
                r_addr <= bus.araddr;
            end else if (r_pend) begin
                if (bus.rvalid && bus.rready) r_pend <= 1'b0;
                else r_cnt <= r_cnt + 1;
            end
            if (aw_fire) begin
                aw_got <= 1'b1;
                w_addr <= bus.awaddr;
            end
            if (w_fire) begin
                w_got  <= 1'b1;
                w_data <= bus.wdata;
                w_strb <= bus.wstrb;
            end
            if ((aw_got || aw_fire) && (w_got || w_fire) && !b_pend) begin
                b_pend <= 1'b1;
                b_cnt  <= 0;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (b_pend) begin
                if (bus.bvalid && bus.bready) begin
                    b_pend <= 1'b0;
                    if (!cur_resp[1]) begin
                        for (int b = 0; b < 4; b++)
                            if (w_strb[b]) smem[w_addr[5:2]][8*b +: 8] <= w_data[8*b +: 8];
                        if (w_addr == 32'ha000_03f8 && w_strb[0]) begin
                            uart_last <= w_data[7:0];
                            $display("[TB] uart tx: %c", w_data[7:0]);
                        end
                    end
                end else begin
                    b_cnt <= b_cnt + 1;
                end
            end
        end
    end

    // Bus monitor totals used for handshake-shape checks.
    int          aw_hi_total = 0, w_hi_total = 0, awaddr_chg_total = 0, overlap_total = 0;
    logic        prev_awvalid = 1'b0;
    logic [31:0] prev_awaddr = '0;

    always @(posedge clk) begin
        if (bus.awvalid) aw_hi_total <= aw_hi_total + 1;
        if (bus.wvalid) w_hi_total <= w_hi_total + 1;
        if (bus.awvalid && prev_awvalid && (bus.awaddr != prev_awaddr))
            awaddr_chg_total <= awaddr_chg_total + 1;
        if (bus.bready && (bus.awvalid || bus.wvalid)) overlap_total <= overlap_total + 1;
        prev_awvalid <= bus.awvalid;
        prev_awaddr  <= bus.awaddr;
    end

    // Reference model: word memory as seen by the LSU.
    logic [31:0] ref_mem [16];

    task automatic resetRef();
        for (int i = 0; i < 16; i++) ref_mem[i] = initWord(i);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request and return #1 after the edge that accepted it.
    task automatic issueRequest(input logic wen, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) checkOutput("accept_wait", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // One full transaction with slave delays; checks data, error, latency.
    task automatic applyStimulus(input string tag, input logic wen, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input logic [1:0] code, input int ard, input int rd,
                                 input int awd, input int wd, input int bd);
        int          lat;
        int          ready_hi;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_err;
        ar_delay = ard; r_delay = rd; aw_delay = awd; w_delay = wd; b_delay = bd;
        cur_resp = code;
        exp_err  = code[1];
        if (wen) begin
            exp_data = 32'h0;
            exp_lat  = 3 + ((awd > wd) ? awd : wd) + bd;
            if (!exp_err)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
        end else begin
            exp_data = ref_mem[addr[5:2]];
            exp_lat  = 2 + ard + rd;
        end
        issueRequest(wen, addr, data, strb);
        lat = 1;
        ready_hi = 0;
        while (!resp_valid && lat < 300) begin
            if (req_ready) ready_hi++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) begin
            checkOutput({tag, "_resp_wait"}, 32'(resp_valid), 32'd1);
            return;
        end
        if (req_ready) ready_hi++;
        checkOutput({tag, "_rdata"}, resp_rdata, exp_data);
        checkOutput({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_busy_ready"}, 32'(ready_hi), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, "_hold_rdata"}, resp_rdata, exp_data);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        resetRef();
    endtask

    initial begin
        int aw0, w0, chg0, ov0, hi;
        resetRef();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
        checkOutput("rst_valids", {27'd0, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 32'd0);
        checkOutput("rst_addr", bus.araddr, 32'd0);

        $display("[TB] zero-wait read");
        applyStimulus("pre1", 1'b1, 32'h8000_0000, 32'h1234_5678, 4'hf, 2'b00, 0, 0, 0, 0, 0);
        applyStimulus("rd_zero", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);

        $display("[TB] uart write");
        applyStimulus("uart", 1'b1, 32'ha000_03f8, 32'h41, 4'h1, 2'b00, 0, 0, 0, 0, 1);
        checkOutput("uart_char", 32'(uart_last), 32'h41);

        $display("[TB] delayed awready");
        aw0 = aw_hi_total; w0 = w_hi_total; chg0 = awaddr_chg_total; ov0 = overlap_total;
        applyStimulus("aw_slow", 1'b1, 32'h4000_0010, 32'hcafe_f00d, 4'hf, 2'b00, 0, 0, 3, 0, 0);
        checkOutput("aw_slow_awvalid_cycles", 32'(aw_hi_total - aw0), 32'd4);
        checkOutput("aw_slow_wvalid_cycles", 32'(w_hi_total - w0), 32'd1);
        checkOutput("aw_slow_awaddr_stable", 32'(awaddr_chg_total - chg0), 32'd0);
        checkOutput("aw_slow_b_overlap", 32'(overlap_total - ov0), 32'd0);

        $display("[TB] slave error read");
        applyStimulus("pre4", 1'b1, 32'h4000_0020, 32'hdead_beef, 4'hf, 2'b00, 0, 0, 0, 0, 0);
        applyStimulus("rd_slverr", 1'b0, 32'h4000_0020, 32'h0, 4'h0, 2'b10, 0, 0, 0, 0, 0);
        applyStimulus("wr_exokay", 1'b1, 32'h4000_0024, 32'h0bad_0001, 4'h3, 2'b01, 1, 0, 0, 2, 0);
        applyStimulus("wr_decerr", 1'b1, 32'h4000_0024, 32'hffff_ffff, 4'hf, 2'b11, 0, 0, 1, 1, 1);

        $display("[TB] reset during read");
        ar_delay = 1000; r_delay = 0;
        issueRequest(1'b0, 32'h4000_0000, 32'h0, 4'h0);
        @(posedge clk); #1;
        checkOutput("rd_stall_arvalid", 32'(bus.arvalid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_arvalid", 32'(bus.arvalid), 32'd0);
        checkOutput("midrst_rready", 32'(bus.rready), 32'd0);
        checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        resetRef();

        $display("[TB] stalled slave");
`ifdef AXI_TIMEOUT_EN
        begin
            int lat;
            ar_delay = 100000; r_delay = 0;
            issueRequest(1'b0, 32'h4000_0004, 32'h0, 4'h0);
            lat = 1;
            while (!resp_valid && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            checkOutput("timeout_latency", 32'(lat), 32'd17);
            checkOutput("timeout_err", 32'(resp_err), 32'd1);
            checkOutput("timeout_rdata", resp_rdata, 32'd0);
            checkOutput("timeout_arvalid", 32'(bus.arvalid), 32'd0);
            @(posedge clk); #1;
            checkOutput("timeout_idle", 32'(req_ready), 32'd1);
        end
`else
        ar_delay = 100000; r_delay = 0;
        issueRequest(1'b0, 32'h4000_0004, 32'h0, 4'h0);
        hi = 0;
        for (int i = 0; i < 120; i++) begin
            if (bus.arvalid && !resp_valid) hi++;
            @(posedge clk); #1;
        end
        checkOutput("stall_arvalid_held", 32'(hi), 32'd120);
        checkOutput("stall_busy", 32'(req_ready), 32'd0);
        doReset();
`endif

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = 32'h4000_0000 | (32'($urandom_range(0, 15)) << 2);
            applyStimulus("rnd", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        cur_resp = 2'b00;
        for (int i = 0; i < 16; i++)
            applyStimulus("sweep", 1'b0, 32'h4000_0000 | (32'(i) << 2), 32'h0, 4'h0,
                          2'b00, i % 2, i % 3, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout got=running exp=finished");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
